one_wire_rx: RTL and testbench

Master-mode 1-Wire read-byte engine. It issues eight read time slots on the open-drain bus, samples the slave's response in each slot, and assembles one byte LSB-first. It sits downstream of the transmitter: the transmitter sends reset/presence and the command byte (e.g. Read ROM 0x33), then this block reads the reply. Optional Dallas CRC-8 accumulation spans successive bytes.

---
 rtl/one_wire_rx.sv | 174 +++++++++++++++++
 tb/tb_one_wire_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/one_wire_rx.sv
// one_wire_rx: master-mode 1-Wire read-byte engine.
// Issues eight read time slots on the open-drain bus, samples the slave's
// response in each slot and assembles one byte LSB-first.
//
// Optional feature: define ONE_WIRE_RX_CRC_EN to build the Dallas CRC-8
// accumulator. Without it crc_out is 0x00, crc_zero is 0 and crc_clr is ignored.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   start         one-cycle request to read a byte (accepted only when idle)
//   busy          high during the read slots and their recovery periods
//   done          one-cycle pulse when the byte is complete
//   rx_byte       last received byte, bit 0 = first bit on the wire
//   crc_clr       clear the CRC accumulator (accepted only when idle)
//   crc_out       running CRC-8 over all sampled bits
//   crc_zero      crc_out == 0
//   one_wire_data open-drain bus, driven low or released, never high
module one_wire_rx #(
    parameter int unsigned CLK_MHZ = 100,
    parameter int unsigned T_RDL   = 6,
    parameter int unsigned T_SMP   = 15,
    parameter int unsigned T_SLOT  = 60,
    parameter int unsigned T_REC   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    input  logic       crc_clr,
    output logic [7:0] crc_out,
    output logic       crc_zero,
    inout  wire        one_wire_data
);

    // Timing must satisfy 0 < RDL < SMP < SLOT and REC >= 1.
    localparam int unsigned RdlCycI  = T_RDL * CLK_MHZ;
    localparam int unsigned SmpCycI  = T_SMP * CLK_MHZ;
    localparam int unsigned SlotCycI = T_SLOT * CLK_MHZ;
    localparam int unsigned RecCycI  = T_REC * CLK_MHZ;
    localparam int unsigned MaxCycI  = (SlotCycI > RecCycI) ? SlotCycI : RecCycI;
    localparam int unsigned CntW     = $clog2(MaxCycI + 1);

    localparam logic [CntW-1:0] RdlCyc   = CntW'(RdlCycI);
    localparam logic [CntW-1:0] SmpCyc   = CntW'(SmpCycI);
    localparam logic [CntW-1:0] SlotLast = CntW'(SlotCycI - 1);
    localparam logic [CntW-1:0] RecLast  = CntW'(RecCycI - 1);

    typedef enum logic [1:0] {StIdle, StSlot, StRec, StFinish} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic [1:0]      sync_q;
    logic            drive_low;
    logic            sample_en;

    // Bus idles high through the pull-up, so the synchronizer resets to ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], one_wire_data};
        end
    end

    // Decoded straight from the state register so reset releases the bus at once.
    assign drive_low     = (state_q == StSlot) && (cnt_q < RdlCyc);
    assign one_wire_data = drive_low ? 1'b0 : 1'bz;
    assign sample_en     = (state_q == StSlot) && (cnt_q == SmpCyc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_byte_q <= rx_byte_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_byte_d = rx_byte_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StSlot;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    shift_d   = '0;
                end
            end
            StSlot: begin
                cnt_d = cnt_q + 1'b1;
                if (sample_en) begin
                    shift_d = {sync_q[1], shift_q[7:1]};
                end
                if (cnt_q == SlotLast) begin
                    state_d = StRec;
                    cnt_d   = '0;
                end
            end
            StRec: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RecLast) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StFinish;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        state_d   = StSlot;
                    end
                end
            end
            StFinish: begin
                rx_byte_d = shift_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy    = (state_q == StSlot) || (state_q == StRec);
    assign done    = (state_q == StFinish);
    assign rx_byte = rx_byte_q;

`ifdef ONE_WIRE_RX_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       crc_fb;

    assign crc_fb = crc_q[0] ^ sync_q[1];

    // Clear wins over any update; no sample can coincide with idle anyway.
    always_comb begin
        crc_d = crc_q;
        if ((state_q == StIdle) && crc_clr) begin
            crc_d = 8'h00;
        end else if (sample_en) begin
            crc_d = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out  = crc_q;
    assign crc_zero = (crc_q == 8'h00);
`else
    logic unused_crc_clr;
    assign unused_crc_clr = crc_clr;
    assign crc_out        = 8'h00;
    assign crc_zero       = 1'b0;
`endif

endmodule

// File: tb/tb_one_wire_rx.sv
// tb_one_wire_rx: self-checking bench for one_wire_rx.
// A slave model answers each read slot (holds the bus low to 30 us for a
// 0-bit, leaves it released for a 1-bit). Expected bytes, cycle positions and
// CRC values come from the slot arithmetic and a byte-level CRC function.
// Timing is scaled down (CLK_MHZ = 2) to keep runs short.
module tb_one_wire_rx;

    localparam int unsigned ClkMhz  = 2;
    localparam int unsigned Rdl     = 6 * ClkMhz;
    localparam int unsigned Smp     = 15 * ClkMhz;
    localparam int unsigned Slot    = 60 * ClkMhz;
    localparam int unsigned Rec     = 1 * ClkMhz;
    localparam int unsigned BitCyc  = Slot + Rec;
    localparam int unsigned ByteCyc = 8 * BitCyc;
    localparam int unsigned HoldCyc = 30 * ClkMhz - 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] rx_byte;
    logic       crc_clr;
    logic [7:0] crc_out;
    logic       crc_zero;
    wire        bus;

    logic [7:0] slave_byte;
    logic [2:0] slave_bit;
    logic       slave_low;
    logic       bus_prev;
    int         hold;

    int         n_pass;
    int         n_total;
    logic [7:0] crc_m;

    pullup (bus);
    assign bus = slave_low ? 1'b0 : 1'bz;

    one_wire_rx #(
        .CLK_MHZ(ClkMhz),
        .T_RDL  (6),
        .T_SMP  (15),
        .T_SLOT (60),
        .T_REC  (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .rx_byte      (rx_byte),
        .crc_clr      (crc_clr),
        .crc_out      (crc_out),
        .crc_zero     (crc_zero),
        .one_wire_data(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: on each master falling edge, answer the next bit of slave_byte.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_prev  <= 1'b1;
            slave_low <= 1'b0;
            slave_bit <= 3'd0;
            hold      <= 0;
        end else begin
            bus_prev <= bus;
            if (!busy) slave_bit <= 3'd0;
            if (slave_low) begin
                if (hold <= 1) slave_low <= 1'b0;
                hold <= hold - 1;
            end else if (bus_prev && !bus) begin
                slave_low <= !slave_byte[slave_bit];
                hold      <= HoldCyc;
                if (busy) slave_bit <= slave_bit + 3'd1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Dallas CRC-8 of one byte, bits taken LSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int b = 0; b < 8; b++) begin
            if (c[0] ^ data[b]) c = (c >> 1) ^ 8'h8C;
            else c = c >> 1;
        end
        return c;
    endfunction

    // Call right after a negedge with the DUT idle. Returns right after the
    // negedge of the idle cycle that follows FINISH.
    task automatic do_read(input logic [7:0] val, input bit mon, input bit inject,
                           input bit clr, output logic [7:0] got);
        int  done_at = 0;
        int  falls = 0;
        int  last_fall = 0;
        int  low_run = 0;
        int  bad_w = 0;
        int  bad_s = 0;
        int  extra = 0;
        logic prev = 1'b1;
        slave_byte = val;
        start   = 1'b1;
        crc_clr = clr;
        @(negedge clk);
        start   = 1'b0;
        crc_clr = 1'b0;
        for (int i = 1; i <= int'(ByteCyc) + 20; i++) begin
            if (i > 1) @(negedge clk);
            if (mon) begin
                if (!bus) begin
                    if (prev) begin
                        if (falls == 0 && i != 1) bad_s++;
                        if (falls > 0 && (i - last_fall) != int'(BitCyc)) bad_s++;
                        last_fall = i;
                        falls++;
                    end
                    low_run++;
                end else if (!prev) begin
                    if (low_run != int'(Rdl)) bad_w++;
                    low_run = 0;
                end
                prev = bus;
            end
            if (inject) start = (i == int'(ByteCyc) / 2);
            if (done) begin
                done_at = i;
                break;
            end
        end
        start = 1'b0;
        check_eq("done_cycle", done_at, ByteCyc + 1);
        check_eq("busy_at_done", {31'd0, busy}, 0);
        if (mon) begin
            check_eq("low_pulses", falls, 8);
            check_eq("pulse_width_bad", bad_w, 0);
            check_eq("slot_spacing_bad", bad_s, 0);
        end
        if (inject) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = rx_byte;
        if (inject) begin
            repeat (20) begin
                @(negedge clk);
                if (busy || done) extra++;
            end
            check_eq("ignored_start", extra, 0);
        end
    endtask

    task automatic read_check(input logic [7:0] val, input bit mon, input bit inject,
                              input bit clr);
        logic [7:0] got;
        do_read(val, mon, inject, clr, got);
        check_eq("rx_byte", got, val);
        if (clr) crc_m = 8'h00;
        crc_m = crc8_byte(crc_m, val);
`ifdef ONE_WIRE_RX_CRC_EN
        check_eq("crc_out", crc_out, crc_m);
        check_eq("crc_zero", {31'd0, crc_zero}, {31'd0, crc_m == 8'h00});
`else
        check_eq("crc_out_off", crc_out, 0);
        check_eq("crc_zero_off", {31'd0, crc_zero}, 0);
`endif
    endtask

    // Abort a read at slot_cnt == off in bit 3 and check the reset state.
    task automatic reset_mid(input int off);
        slave_byte = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * BitCyc + off) @(negedge clk);
        check_eq("busy_pre_reset", {31'd0, busy}, 1);
        check_eq("bus_pre_reset", {31'd0, bus}, {31'd0, off >= int'(Rdl)});
        rst_n = 1'b0;
        #1;
        check_eq("rst_bus_released", {31'd0, bus}, 1);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_done", {31'd0, done}, 0);
        check_eq("rst_rx_byte", rx_byte, 0);
        check_eq("rst_crc_out", crc_out, 0);
        crc_m = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0] rom [8];

    initial begin
        n_pass  = 0;
        n_total = 0;
        crc_m   = 8'h00;
        rst_n   = 1'b0;
        start   = 1'b0;
        crc_clr = 1'b0;
        slave_byte = 8'hFF;
        rom = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
        repeat (3) @(negedge clk);
        check_eq("reset_busy", {31'd0, busy}, 0);
        check_eq("reset_done", {31'd0, done}, 0);
        check_eq("reset_rx_byte", rx_byte, 0);
        check_eq("reset_crc_out", crc_out, 0);
`ifdef ONE_WIRE_RX_CRC_EN
        check_eq("reset_crc_zero", {31'd0, crc_zero}, 1);
`else
        check_eq("reset_crc_zero", {31'd0, crc_zero}, 0);
`endif
        check_eq("reset_bus", {31'd0, bus}, 1);
        rst_n = 1'b1;
        @(negedge clk);

        read_check(8'hA5, 1'b0, 1'b0, 1'b0);
        read_check(8'hFF, 1'b1, 1'b0, 1'b0);
        read_check(8'h00, 1'b0, 1'b1, 1'b0);

        // ROM reply with valid CRC, then with a corrupted CRC byte.
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 8; k++) begin
                read_check((k == 7 && pass == 1) ? 8'hA3 : rom[k], 1'b0, 1'b0, k == 0);
            end
`ifdef ONE_WIRE_RX_CRC_EN
            check_eq("rom_crc_zero", {31'd0, crc_zero}, {31'd0, pass == 0});
`endif
        end

        reset_mid(Smp);
        read_check(8'h3C, 1'b0, 1'b0, 1'b0);
        reset_mid(2);

        for (int k = 0; k < 6; k++) begin
            read_check(8'($urandom), 1'b0, k == 3, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
